melody_seq: RTL and testbench

MELODY_SEQ -- requirements
Module: melody_seq

---
 rtl/melody_seq_if.sv | 11 +
 rtl/melody_seq.sv | 136 +++++++++++++
 tb/tb_melody_seq.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/melody_seq_if.sv
// Score memory bus between the melody sequencer (master) and the score store (slave).
interface melody_seq_if #(
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned DATA_WIDTH = 21
);
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;

  modport master (output mem_addr, input mem_data);
  modport slave  (input mem_addr, output mem_data);
endinterface

// File: rtl/melody_seq.sv
// Melody sequencer: walks a {div, dur} score, emitting a tone divider and enable per note,
// timed in tempo ticks, with looping, octave transpose and end-of-note articulation gap.
module melody_seq #(
  parameter int unsigned DIV_WIDTH  = 17,
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned DUR_WIDTH  = 4,
  parameter bit          GAP_EN     = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tempo_tick,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 loop,
  input  logic [1:0]           octave,
  melody_seq_if.master         mem,
  output logic [DIV_WIDTH-1:0] div,
  output logic                 enable,
  output logic                 busy,
  output logic                 done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] LOAD  = 2'd2;
  localparam logic [1:0] PLAY  = 2'd3;

  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;
  localparam logic [DUR_WIDTH-1:0]  DUR_ONE   = DUR_WIDTH'(1);

  logic [1:0]            state, state_n;
  logic [ADDR_WIDTH-1:0] addr_q, addr_n;
  logic [DIV_WIDTH-1:0]  div_n;
  logic [DUR_WIDTH-1:0]  remaining, rem_n;
  logic                  enable_n, busy_n, done_n;
  logic                  eos;
  logic [DIV_WIDTH-1:0]  ld_div;
  logic [DUR_WIDTH-1:0]  ld_dur;

  assign ld_div       = mem.mem_data[DUR_WIDTH +: DIV_WIDTH];
  assign ld_dur       = mem.mem_data[DUR_WIDTH-1:0];
  assign mem.mem_addr = addr_q;

  // Next-state and next-output logic.
  always_comb begin
    state_n = state;
    addr_n  = addr_q;
    div_n   = div;
    rem_n   = remaining;
    done_n  = 1'b0;
    eos     = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_n = FETCH;
          addr_n  = '0;
        end
      end
      FETCH: state_n = LOAD;
      LOAD: begin
        if (ld_dur != '0) begin
          div_n   = ld_div >> octave;
          rem_n   = ld_dur;
          state_n = PLAY;
        end else begin
          eos = 1'b1;
        end
      end
      PLAY: begin
        if (tempo_tick) begin
          rem_n = remaining - DUR_ONE;
          if (remaining == DUR_ONE) begin
            if (addr_q == ADDR_LAST) begin
              eos = 1'b1;
            end else begin
              addr_n  = addr_q + ADDR_WIDTH'(1);
              state_n = FETCH;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // An end marker at address 0 never loops, so a blank score cannot spin forever.
    if (eos) begin
      if (loop && (addr_q != '0)) begin
        addr_n  = '0;
        state_n = FETCH;
      end else begin
        state_n = IDLE;
        done_n  = 1'b1;
      end
    end

    if (state_n == IDLE) begin
      div_n  = '0;
      addr_n = '0;
      rem_n  = '0;
    end

    if (stop) begin
      state_n = IDLE;
      div_n   = '0;
      addr_n  = '0;
      rem_n   = '0;
      done_n  = 1'b0;
    end

    busy_n   = (state_n != IDLE);
    enable_n = (state_n == PLAY) && (div_n != '0) && !(GAP_EN && (rem_n == DUR_ONE));
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      div       <= '0;
      remaining <= '0;
      enable    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      addr_q    <= addr_n;
      div       <= div_n;
      remaining <= rem_n;
      enable    <= enable_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

endmodule

// File: tb/tb_melody_seq.sv
// Self-checking bench for melody_seq: directed scores plus random scores compared
// per tempo-tick slot against a score-walking reference model.
module tb_melody_seq;

  localparam int unsigned DW  = 17;
  localparam int unsigned AW  = 7;
  localparam int unsigned UW  = 4;
  localparam int unsigned WW  = DW + UW;
  localparam int unsigned AW2 = 2;
  localparam int          NENT = 1 << AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, tempo_tick, start, start2, stop, loop;
  logic [1:0]    octave;
  logic [DW-1:0] div, div2;
  logic          enable, busy, done, enable2, busy2, done2;

  melody_seq_if #(.ADDR_WIDTH(AW),  .DATA_WIDTH(WW)) mif ();
  melody_seq_if #(.ADDR_WIDTH(AW2), .DATA_WIDTH(WW)) mif2 ();

  melody_seq #(.DIV_WIDTH(DW), .ADDR_WIDTH(AW), .DUR_WIDTH(UW), .GAP_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst), .tempo_tick(tempo_tick), .start(start), .stop(stop),
    .loop(loop), .octave(octave), .mem(mif.master), .div(div), .enable(enable),
    .busy(busy), .done(done)
  );

  melody_seq #(.DIV_WIDTH(DW), .ADDR_WIDTH(AW2), .DUR_WIDTH(UW), .GAP_EN(1'b0)) u_dut2 (
    .clk(clk), .rst(rst), .tempo_tick(tempo_tick), .start(start2), .stop(stop),
    .loop(loop), .octave(octave), .mem(mif2.master), .div(div2), .enable(enable2),
    .busy(busy2), .done(done2)
  );

  logic [WW-1:0] score  [0:NENT-1];
  logic [WW-1:0] score2 [0:3];

  // Synchronous score stores: data valid one cycle after the address.
  always @(posedge clk) begin
    mif.mem_data  <= score[mif.mem_addr];
    mif2.mem_data <= score2[mif2.mem_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int done2_cnt = 0;

  always @(negedge clk) begin
    if (done)  done_cnt++;
    if (done2) done2_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: expected (div, enable) for each tempo-tick slot of a playback.
  logic [DW-1:0] exp_div [$];
  bit            exp_en  [$];

  task automatic build_expect(input bit lp, input logic [1:0] oc, input int maxslots,
                              output bit ends);
    int a;
    logic [WW-1:0] w;
    int d;
    logic [DW-1:0] v;
    bit at_end;
    a = 0;
    ends = 1'b0;
    exp_div.delete();
    exp_en.delete();
    for (int guard = 0; guard < 1000; guard++) begin
      w = score[a];
      d = int'(w[UW-1:0]);
      if (d != 0 && exp_div.size() >= maxslots) break;
      at_end = 1'b0;
      if (d == 0) begin
        at_end = 1'b1;
      end else begin
        v = w[WW-1:UW] >> oc;
        for (int k = d; k >= 1; k--) begin
          exp_div.push_back(v);
          exp_en.push_back((v != 0) && (k != 1));
        end
        if (a == NENT - 1) at_end = 1'b1;
        else a++;
      end
      if (at_end) begin
        if (lp && a != 0) a = 0;
        else begin
          ends = 1'b1;
          break;
        end
      end
    end
  endtask

  task automatic tick_gap();
    tempo_tick = 1'b1;
    @(negedge clk);
    tempo_tick = 1'b0;
    repeat ($urandom_range(4, 7)) @(negedge clk);
  endtask

  task automatic run_score(input string name, input bit lp, input logic [1:0] oc,
                           input int maxslots, input bit tick_with_start);
    bit ends;
    build_expect(lp, oc, maxslots, ends);
    done_cnt = 0;
    loop = lp;
    octave = oc;
    @(negedge clk);
    start = 1'b1;
    tempo_tick = tick_with_start;
    @(negedge clk);
    start = 1'b0;
    tempo_tick = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < exp_div.size(); i++) begin
      check({name, " div"}, 32'(div), 32'(exp_div[i]));
      check({name, " enable"}, 32'(enable), 32'(exp_en[i]));
      tick_gap();
    end
    if (ends) begin
      for (int t = 0; t < 10 && busy; t++) @(negedge clk);
      check({name, " end busy"}, 32'(busy), 32'd0);
      check({name, " end div"}, 32'(div), 32'd0);
      check({name, " end enable"}, 32'(enable), 32'd0);
      check({name, " end addr"}, 32'(mif.mem_addr), 32'd0);
      check({name, " done count"}, 32'(done_cnt), 32'd1);
    end else begin
      check({name, " busy before stop"}, 32'(busy), 32'd1);
      check({name, " no done before stop"}, 32'(done_cnt), 32'd0);
      stop = 1'b1;
      start = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      start = 1'b0;
      check({name, " stop busy"}, 32'(busy), 32'd0);
      check({name, " stop div"}, 32'(div), 32'd0);
      check({name, " stop enable"}, 32'(enable), 32'd0);
      check({name, " stop addr"}, 32'(mif.mem_addr), 32'd0);
      repeat (3) @(negedge clk);
      check({name, " stop no done"}, 32'(done_cnt), 32'd0);
      check({name, " start ignored"}, 32'(busy), 32'd0);
    end
  endtask

  function automatic logic [WW-1:0] entry(input int dv, input int du);
    return {DW'(dv), UW'(du)};
  endfunction

  task automatic clear_score();
    for (int i = 0; i < NENT; i++) score[i] = '0;
  endtask

  initial begin
    rst = 1'b1; tempo_tick = 1'b0; start = 1'b0; start2 = 1'b0; stop = 1'b0;
    loop = 1'b0; octave = 2'd0;
    clear_score();
    for (int i = 0; i < 4; i++) score2[i] = entry((i + 1) * 10, 1);
    repeat (3) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset enable", 32'(enable), 32'd0);
    check("reset div", 32'(div), 32'd0);
    check("reset addr", 32'(mif.mem_addr), 32'd0);
    check("reset busy2", 32'(busy2), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    score[0] = entry(100, 2); score[1] = entry(200, 1); score[2] = entry(0, 0);
    run_score("basic", 1'b0, 2'd0, 50, 1'b1);
    run_score("loop", 1'b1, 2'd0, 6, 1'b0);

    clear_score();
    score[0] = entry(0, 3);
    run_score("rest", 1'b0, 2'd0, 50, 1'b0);

    clear_score();
    score[0] = entry(1000, 1);
    run_score("octave", 1'b0, 2'd2, 50, 1'b0);

    clear_score();
    score[0] = entry(77, 0);
    run_score("marker0 loop", 1'b1, 2'd1, 50, 1'b0);

    for (int it = 0; it < 8; it++) begin
      int n;
      clear_score();
      n = $urandom_range(1, 5);
      for (int j = 0; j < n; j++)
        score[j] = entry(($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, (1 << DW) - 1),
                         $urandom_range(1, 3));
      run_score("random", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 10, 1'b0);
    end

    // Four-entry score, no end marker, no articulation gap.
    loop = 1'b0; octave = 2'd0; done2_cnt = 0;
    start2 = 1'b1; @(negedge clk); start2 = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check("aw2 div", 32'(div2), 32'((i + 1) * 10));
      check("aw2 enable", 32'(enable2), 32'd1);
      tick_gap();
    end
    check("aw2 done count", 32'(done2_cnt), 32'd1);
    check("aw2 busy", 32'(busy2), 32'd0);
    check("aw2 div idle", 32'(div2), 32'd0);

    loop = 1'b1; done2_cnt = 0;
    start2 = 1'b1; @(negedge clk); start2 = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("aw2 wrap div", 32'(div2), 32'(((i % 4) + 1) * 10));
      tick_gap();
    end
    check("aw2 wrap no done", 32'(done2_cnt), 32'd0);
    check("aw2 wrap busy", 32'(busy2), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midplay rst busy", 32'(busy2), 32'd0);
    check("midplay rst div", 32'(div2), 32'd0);
    check("midplay rst enable", 32'(enable2), 32'd0);
    check("midplay rst done", 32'(done2), 32'd0);
    check("midplay rst addr", 32'(mif2.mem_addr), 32'd0);
    repeat (3) @(negedge clk);
    check("midplay rst no done", 32'(done2_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
